cbfp1_shift_ctrl: RTL and testbench



---
 rtl/cbfp1_ctrl_pkg.sv | 41 ++++
 rtl/cbfp1_shift_ctrl_if.sv | 32 +++
 rtl/cbfp1_lsc_min.sv | 26 ++
 rtl/cbfp1_shift_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cbfp1_shift_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbfp1_ctrl_pkg.sv
// rtl/cbfp1_ctrl_pkg.sv - shared widths, types and leading-sign helpers for the CBFP1 shift controller
package cbfp1_ctrl_pkg;

    localparam int INPUT_WIDTH = 25;
    localparam int BLOCK_SIZE  = 8;
    localparam int GROUPS      = 4;
    localparam int SHIFT_WIDTH = 5;
    localparam int GCNT_W      = $clog2(GROUPS);
    localparam int CNT_W       = $clog2(INPUT_WIDTH);
    localparam int SHIFT_MAX   = (2 ** SHIFT_WIDTH) - 1;

    typedef logic [SHIFT_WIDTH-1:0] lsc_t;
    typedef logic [CNT_W-1:0]       cnt_t;
    typedef logic signed [BLOCK_SIZE-1:0][INPUT_WIDTH-1:0] group_t;

    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

    // Count of bits directly below the MSB that repeat the MSB.
    function automatic cnt_t lsc(input logic [INPUT_WIDTH-1:0] x);
        cnt_t n;
        logic run;
        n   = '0;
        run = 1'b1;
        for (int i = INPUT_WIDTH - 2; i >= 0; i--) begin
            if (run && (x[i] == x[INPUT_WIDTH-1])) begin
                n = n + cnt_t'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic lsc_t sat(input cnt_t v);
        if (int'(v) > SHIFT_MAX) begin
            return lsc_t'(SHIFT_MAX);
        end
        return lsc_t'(v);
    endfunction

endpackage

// File: rtl/cbfp1_shift_ctrl_if.sv
// rtl/cbfp1_shift_ctrl_if.sv - group input bus and shift-array output bus of the CBFP1 controller
interface cbfp1_shift_ctrl_if;
    import cbfp1_ctrl_pkg::*;

    logic   in_valid;
    group_t in_R_add;
    group_t in_Q_add;
    group_t in_R_sub;
    group_t in_Q_sub;

    logic   en;
    logic   out_last;
    lsc_t   shift_value_add;
    lsc_t   shift_value_sub;
    group_t out_R_add;
    group_t out_Q_add;
    group_t out_R_sub;
    group_t out_Q_sub;

    modport master (
        output in_valid, in_R_add, in_Q_add, in_R_sub, in_Q_sub,
        input  en, out_last, shift_value_add, shift_value_sub,
        input  out_R_add, out_Q_add, out_R_sub, out_Q_sub
    );

    modport slave (
        input  in_valid, in_R_add, in_Q_add, in_R_sub, in_Q_sub,
        output en, out_last, shift_value_add, shift_value_sub,
        output out_R_add, out_Q_add, out_R_sub, out_Q_sub
    );

endinterface

// File: rtl/cbfp1_lsc_min.sv
// rtl/cbfp1_lsc_min.sv - minimum leading-sign count over one R group and one Q group
module cbfp1_lsc_min import cbfp1_ctrl_pkg::*; (
    input  group_t i_r,
    input  group_t i_q,
    output cnt_t   o_min
);

    cnt_t w_min;
    cnt_t w_r;
    cnt_t w_q;

    always_comb begin
        w_min = cnt_t'(INPUT_WIDTH - 1);
        w_r   = '0;
        w_q   = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            w_r = lsc(i_r[i]);
            w_q = lsc(i_q[i]);
            if (w_r < w_min) w_min = w_r;
            if (w_q < w_min) w_min = w_q;
        end
    end

    assign o_min = w_min;

endmodule

// File: rtl/cbfp1_shift_ctrl.sv
// rtl/cbfp1_shift_ctrl.sv - ping-pong block buffer computing CBFP1 shift values and replaying blocks to the shift array
module cbfp1_shift_ctrl import cbfp1_ctrl_pkg::*; (
    input logic               clk,
    input logic               rstn,
    cbfp1_shift_ctrl_if.slave bus
);

    logic              r_wb;
    logic [GCNT_W-1:0] r_wcnt;
    cnt_t              r_run_add;
    cnt_t              r_run_sub;
    logic [1:0]        r_full;
    lsc_t              r_bank_sa [2];
    lsc_t              r_bank_ss [2];

    group_t r_mem_ra [2][GROUPS];
    group_t r_mem_qa [2][GROUPS];
    group_t r_mem_rs [2][GROUPS];
    group_t r_mem_qs [2][GROUPS];

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic              r_rb;
    logic              w_rb_nxt;
    logic [GCNT_W-1:0] r_rcnt;
    logic [GCNT_W-1:0] w_rcnt_nxt;
    logic              w_issue;
    logic              w_rd_last;
    logic              w_rd_clr;

    logic   r_en;
    logic   r_last;
    lsc_t   r_sv_add;
    lsc_t   r_sv_sub;
    group_t r_out_ra;
    group_t r_out_qa;
    group_t r_out_rs;
    group_t r_out_qs;

    cnt_t w_grp_add;
    cnt_t w_grp_sub;
    cnt_t w_new_add;
    cnt_t w_new_sub;
    logic w_wlast;

    cbfp1_lsc_min u_min_add (
        .i_r   (bus.in_R_add),
        .i_q   (bus.in_Q_add),
        .o_min (w_grp_add)
    );

    cbfp1_lsc_min u_min_sub (
        .i_r   (bus.in_R_sub),
        .i_q   (bus.in_Q_sub),
        .o_min (w_grp_sub)
    );

    assign w_wlast   = (r_wcnt == GCNT_W'(GROUPS - 1));
    // The first group of a block reloads the running min instead of merging.
    assign w_new_add = ((r_wcnt == '0) || (w_grp_add < r_run_add)) ? w_grp_add : r_run_add;
    assign w_new_sub = ((r_wcnt == '0) || (w_grp_sub < r_run_sub)) ? w_grp_sub : r_run_sub;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wb      <= 1'b0;
            r_wcnt    <= '0;
            r_run_add <= cnt_t'(INPUT_WIDTH - 1);
            r_run_sub <= cnt_t'(INPUT_WIDTH - 1);
            for (int b = 0; b < 2; b++) begin
                r_bank_sa[b] <= '0;
                r_bank_ss[b] <= '0;
            end
        end else if (bus.in_valid) begin
            r_run_add <= w_new_add;
            r_run_sub <= w_new_sub;
            if (w_wlast) begin
                r_bank_sa[r_wb] <= sat(w_new_add);
                r_bank_ss[r_wb] <= sat(w_new_sub);
                r_wcnt          <= '0;
                r_wb            <= ~r_wb;
            end else begin
                r_wcnt <= r_wcnt + GCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            r_mem_ra[r_wb][r_wcnt] <= bus.in_R_add;
            r_mem_qa[r_wb][r_wcnt] <= bus.in_Q_add;
            r_mem_rs[r_wb][r_wcnt] <= bus.in_R_sub;
            r_mem_qs[r_wb][r_wcnt] <= bus.in_Q_sub;
        end
    end

    // Drain clears bank rb while the writer may fill the other bank; a fill mark wins a tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_full <= '0;
        end else begin
            if (w_rd_clr) r_full[r_rb] <= 1'b0;
            if (bus.in_valid && w_wlast) r_full[r_wb] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            r_rb    <= 1'b0;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rb    <= w_rb_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    // Group 0 is issued straight from R_IDLE so en rises one edge after the bank fills.
    always_comb begin
        w_state_nxt = r_state;
        w_rb_nxt    = r_rb;
        w_rcnt_nxt  = r_rcnt;
        w_issue     = 1'b0;
        w_rd_last   = 1'b0;
        w_rd_clr    = 1'b0;
        case (r_state)
            R_IDLE:  w_issue = r_full[r_rb];
            R_DRAIN: w_issue = 1'b1;
            default: w_state_nxt = R_IDLE;
        endcase
        if (w_issue) begin
            w_rd_last = (r_rcnt == GCNT_W'(GROUPS - 1));
            if (w_rd_last) begin
                w_rd_clr    = 1'b1;
                w_rb_nxt    = ~r_rb;
                w_rcnt_nxt  = '0;
                w_state_nxt = r_full[~r_rb] ? R_DRAIN : R_IDLE;
            end else begin
                w_rcnt_nxt  = r_rcnt + GCNT_W'(1);
                w_state_nxt = R_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_en     <= 1'b0;
            r_last   <= 1'b0;
            r_sv_add <= '0;
            r_sv_sub <= '0;
            r_out_ra <= '0;
            r_out_qa <= '0;
            r_out_rs <= '0;
            r_out_qs <= '0;
        end else if (w_issue) begin
            r_en     <= 1'b1;
            r_last   <= w_rd_last;
            r_sv_add <= r_bank_sa[r_rb];
            r_sv_sub <= r_bank_ss[r_rb];
            r_out_ra <= r_mem_ra[r_rb][r_rcnt];
            r_out_qa <= r_mem_qa[r_rb][r_rcnt];
            r_out_rs <= r_mem_rs[r_rb][r_rcnt];
            r_out_qs <= r_mem_qs[r_rb][r_rcnt];
        end else begin
            r_en   <= 1'b0;
            r_last <= 1'b0;
        end
    end

    assign bus.en              = r_en;
    assign bus.out_last        = r_last;
    assign bus.shift_value_add = r_sv_add;
    assign bus.shift_value_sub = r_sv_sub;
    assign bus.out_R_add       = r_out_ra;
    assign bus.out_Q_add       = r_out_qa;
    assign bus.out_R_sub       = r_out_rs;
    assign bus.out_Q_sub       = r_out_qs;

endmodule

// File: tb/tb_cbfp1_shift_ctrl.sv
// tb/tb_cbfp1_shift_ctrl.sv - scoreboard bench for the CBFP1 shift controller
module tb_cbfp1_shift_ctrl;
    import cbfp1_ctrl_pkg::*;

    typedef struct {
        group_t ra;
        group_t qa;
        group_t rs;
        group_t qs;
        lsc_t   sa;
        lsc_t   ss;
        logic   last;
        int     cyc;
        int     blk;
        int     grp;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t exp_q [$];
    group_t blk [4][GROUPS];

    cbfp1_shift_ctrl_if bus ();

    cbfp1_shift_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstn && bus.en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_group: en=1 at cyc=%0d, required no output", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || bus.out_last !== e.last ||
                    bus.shift_value_add !== e.sa || bus.shift_value_sub !== e.ss ||
                    bus.out_R_add !== e.ra || bus.out_Q_add !== e.qa ||
                    bus.out_R_sub !== e.rs || bus.out_Q_sub !== e.qs) begin
                    miscompares++;
                    $display("FAIL out_group blk=%0d grp=%0d: got cyc=%0d last=%b sa=%0d ss=%0d ra0=%h qs7=%h, required cyc=%0d last=%b sa=%0d ss=%0d ra0=%h qs7=%h",
                             e.blk, e.grp, cyc, bus.out_last, bus.shift_value_add, bus.shift_value_sub,
                             bus.out_R_add[0], bus.out_Q_sub[7], e.cyc, e.last, e.sa, e.ss, e.ra[0], e.qs[7]);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rstn && bus.in_valid) begin
            vectors++;
            if (dut.r_full[dut.r_wb]) begin
                miscompares++;
                $display("FAIL no_overwrite: write into full bank %0d at cyc=%0d, required bank empty", dut.r_wb, cyc);
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    function automatic int model_lsc(input logic [INPUT_WIDTH-1:0] x);
        logic signed [INPUT_WIDTH-1:0] y;
        for (int n = INPUT_WIDTH - 1; n > 0; n--) begin
            y = $signed(x << n) >>> n;
            if (y == $signed(x)) return n;
        end
        return 0;
    endfunction

    function automatic int model_shift(input int pa, input int pb);
        int m;
        m = INPUT_WIDTH - 1;
        for (int g = 0; g < GROUPS; g++)
            for (int l = 0; l < BLOCK_SIZE; l++) begin
                if (model_lsc(blk[pa][g][l]) < m) m = model_lsc(blk[pa][g][l]);
                if (model_lsc(blk[pb][g][l]) < m) m = model_lsc(blk[pb][g][l]);
            end
        return m;
    endfunction

    task automatic clear_blk();
        for (int p = 0; p < 4; p++)
            for (int g = 0; g < GROUPS; g++) blk[p][g] = '0;
    endtask

    task automatic fill_rand(input int bits);
        int r;
        for (int p = 0; p < 4; p++)
            for (int g = 0; g < GROUPS; g++)
                for (int l = 0; l < BLOCK_SIZE; l++) begin
                    r = int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
                    blk[p][g][l] = INPUT_WIDTH'(r);
                end
    endtask

    // Leaves in_valid high after the last group so blocks can run back to back.
    task automatic send_block(input int sa, input int ss, input int id, input bit gaps);
        int   t;
        exp_t e;
        t = 0;
        for (int g = 0; g < GROUPS; g++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_R_add = blk[0][g];
            bus.in_Q_add = blk[1][g];
            bus.in_R_sub = blk[2][g];
            bus.in_Q_sub = blk[3][g];
            t = cyc + 1;
        end
        for (int g = 0; g < GROUPS; g++) begin
            e.ra = blk[0][g]; e.qa = blk[1][g]; e.rs = blk[2][g]; e.qs = blk[3][g];
            e.sa = lsc_t'(sa); e.ss = lsc_t'(ss);
            e.last = (g == GROUPS - 1);
            e.cyc = t + 1 + g;
            e.blk = id;
            e.grp = g;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drained(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d groups still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_reset();
        #2 rstn = 1'b0;
        #1;
        check("reset_en_async", int'(bus.en), 0);
        check("reset_last", int'(bus.out_last), 0);
        check("reset_sv_add", int'(bus.shift_value_add), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_R_add = '0; bus.in_Q_add = '0; bus.in_R_sub = '0; bus.in_Q_sub = '0;
        repeat (3) @(negedge clk);
        check("rst_en", int'(bus.en), 0);
        check("rst_last", int'(bus.out_last), 0);
        check("rst_sv_add", int'(bus.shift_value_add), 0);
        check("rst_sv_sub", int'(bus.shift_value_sub), 0);
        check("rst_data_zero", int'(bus.out_R_add == '0 && bus.out_Q_sub == '0), 1);
        rstn = 1'b1;
        idle(2);

        // Add path peak +0xFFF, sub path peak -4096: both lsc 12.
        clear_blk();
        for (int g = 0; g < GROUPS; g++)
            for (int l = 0; l < BLOCK_SIZE; l++) begin
                blk[0][g][l] = INPUT_WIDTH'(l + 16 * g);
                blk[2][g][l] = INPUT_WIDTH'(-(l + 1));
            end
        blk[1][2][5] = 25'h000FFF;
        blk[3][1][3] = INPUT_WIDTH'(-4096);
        send_block(12, 12, 1, 1'b0);
        idle(1);
        wait_drained(40);
        idle(2);
        check("hold_sv_add", int'(bus.shift_value_add), 12);
        check("hold_sv_sub", int'(bus.shift_value_sub), 12);
        check("idle_en", int'(bus.en), 0);

        // All-zero block, with -1 in the very last sample: stays 24/24.
        clear_blk();
        blk[0][GROUPS-1][BLOCK_SIZE-1] = 25'h1FFFFFF;
        send_block(24, 24, 2, 1'b0);
        idle(1);
        // Same, but the last sample of Q_sub is 0x100 -> sub lsc 15.
        clear_blk();
        blk[3][GROUPS-1][BLOCK_SIZE-1] = 25'h0000100;
        send_block(24, 15, 3, 1'b0);
        idle(1);

        // Independent paths: add sample of 24-bit magnitude, sub peak 0xFF.
        clear_blk();
        blk[0][1][6] = 25'h0800000;
        blk[2][3][0] = 25'h00000FF;
        send_block(0, 16, 4, 1'b0);
        idle(1);
        wait_drained(40);

        // Three blocks back to back; exact cycles prove no bubble.
        fill_rand(10);
        send_block(model_shift(0, 1), model_shift(2, 3), 5, 1'b0);
        fill_rand(20);
        send_block(model_shift(0, 1), model_shift(2, 3), 6, 1'b0);
        fill_rand(6);
        send_block(model_shift(0, 1), model_shift(2, 3), 7, 1'b0);
        idle(1);
        wait_drained(60);

        // Random input gaps.
        for (int b = 0; b < 3; b++) begin
            fill_rand(8 + 5 * b);
            send_block(model_shift(0, 1), model_shift(2, 3), 8 + b, 1'b1);
        end
        idle(1);
        wait_drained(100);

        // Reset while draining at rcnt==1.
        fill_rand(12);
        send_block(model_shift(0, 1), model_shift(2, 3), 11, 1'b0);
        idle(1);
        while (exp_q.size() > GROUPS - 1) @(negedge clk);
        pulse_reset();

        // Reset mid-fill after two groups: the partial block must vanish.
        fill_rand(4);
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_R_add = blk[0][g]; bus.in_Q_add = blk[1][g];
            bus.in_R_sub = blk[2][g]; bus.in_Q_sub = blk[3][g];
        end
        idle(1);
        pulse_reset();
        idle(1);
        clear_blk();
        blk[0][1][6] = 25'h0800000;
        blk[2][3][0] = 25'h00000FF;
        blk[1][0][2] = 25'h0000042;
        send_block(0, 16, 12, 1'b0);
        idle(1);
        wait_drained(40);
        idle(3);
        check("final_en", int'(bus.en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
